// File: rtl/dsp_pkg.sv
// Shared constants, FIFO entry layout and the round/shift/saturate helper.
package dsp_pkg;

  localparam int unsigned DEF_WIDTH     = 16;
  localparam int unsigned DEF_OUT_WIDTH = 16;
  localparam int unsigned DEF_RSH_BITS  = 5;
  localparam int unsigned DEF_DEPTH     = 4;
  localparam int unsigned RES_W         = 2 * DEF_WIDTH;

  // Widest supported result is 64 bits; one extra bit absorbs the rounding add.
  localparam int unsigned MAX_RES_W = 64;
  localparam int unsigned SCALE_W   = MAX_RES_W + 1;

  typedef struct packed {
    logic                     sat;
    logic [DEF_OUT_WIDTH-1:0] data;
  } entry_t;

  // Round-half-up arithmetic right shift of a sign-extended value, with
  // optional clipping to a signed out_w range. Caller keeps the low out_w bits.
  function automatic logic signed [SCALE_W-1:0] scale_round(
    input  logic signed [SCALE_W-1:0] v,
    input  int unsigned               sh,
    input  int unsigned               res_w,
    input  int unsigned               out_w,
    input  logic                      sat_en,
    output logic                      sat
  );
    logic signed [SCALE_W-1:0] r;
    logic signed [SCALE_W-1:0] hi;
    logic signed [SCALE_W-1:0] lo;
    sat = 1'b0;
    hi  = signed'((SCALE_W'(1) << (out_w - 1)) - SCALE_W'(1));
    lo  = ~hi;
    if (sh >= res_w) begin
      r = v[SCALE_W-1] ? '1 : '0;
    end else if (sh == 0) begin
      r = v;
    end else begin
      r = v + signed'(SCALE_W'(1) << (sh - 1));
      r = r >>> sh;
    end
    if (sat_en) begin
      if (r > hi) begin
        r   = hi;
        sat = 1'b1;
      end else if (r < lo) begin
        r   = lo;
        sat = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO succeeds only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Storage write; contents are masked at the output while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dsp_result_collector.sv
// Captures DSP results, scales/saturates them and queues them for a consumer.
module dsp_result_collector
  import dsp_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int unsigned RSH_BITS  = DEF_RSH_BITS,
  parameter int unsigned DEPTH     = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     compare_res,
  input  logic [2*WIDTH-1:0]       res_in,
  input  logic [RSH_BITS-1:0]      rshift,
  input  logic                     sat_en,
  input  logic                     clear_ovf,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic                     out_sat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned RW = 2 * WIDTH;

  logic                 s1_valid;
  logic [RW-1:0]        s1_res;
  logic [RSH_BITS-1:0]  s1_rsh;
  logic                 s1_sat_en;

  logic [OUT_WIDTH-1:0] scaled_data;
  logic                 scaled_sat;
  logic [OUT_WIDTH:0]   head;
  logic                 full;
  logic                 empty;
  logic                 pop;

  // Stage 1: capture the result and its scaling controls on the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_res    <= '0;
      s1_rsh    <= '0;
      s1_sat_en <= 1'b0;
    end else begin
      s1_valid <= compare_res;
      if (compare_res) begin
        s1_res    <= res_in;
        s1_rsh    <= rshift;
        s1_sat_en <= sat_en;
      end
    end
  end

  // Stage 2: round, shift and optionally saturate the captured result.
  always_comb begin
    scaled_sat  = 1'b0;
    scaled_data = OUT_WIDTH'(scale_round(SCALE_W'(signed'(s1_res)), 32'(s1_rsh),
                                         RW, OUT_WIDTH, s1_sat_en, scaled_sat));
  end

  assign pop       = out_valid & out_ready;
  assign out_valid = ~empty;
  assign out_data  = head[OUT_WIDTH-1:0];
  assign out_sat   = head[OUT_WIDTH];

  sync_fifo #(
    .WIDTH (OUT_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_valid),
    .wdata ({scaled_sat, scaled_data}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Sticky drop flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (s1_valid & full & ~pop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsp_result_collector.sv
// Directed bench with a queue-based reference model checked every cycle.
module tb_dsp_result_collector;
  import dsp_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        compare_res = 1'b0;
  logic [31:0] res_in = '0;
  logic [4:0]  rshift = '0;
  logic        sat_en = 1'b0;
  logic        clear_ovf = 1'b0;
  logic [15:0] out_data;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_result_collector #(
    .WIDTH(16), .OUT_WIDTH(16), .RSH_BITS(5), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .compare_res(compare_res), .res_in(res_in),
    .rshift(rshift), .sat_en(sat_en), .clear_ovf(clear_ovf),
    .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference scaling in plain integer arithmetic: floor((v + half) / 2^sh).
  function automatic entry_t model_scale(input logic [31:0] r, input int sh, input bit s);
    entry_t e;
    longint v;
    longint num;
    longint den;
    longint q;
    v = longint'(signed'(r));
    if (sh >= RES_W) begin
      q = (v < 0) ? -1 : 0;
    end else if (sh == 0) begin
      q = v;
    end else begin
      den = longint'(1) << sh;
      num = v + den / 2;
      q = num / den;
      if ((num % den) != 0 && num < 0) q = q - 1;
    end
    e.sat = 1'b0;
    if (s && q > 32767) begin
      q = 32767;
      e.sat = 1'b1;
    end else if (s && q < -32768) begin
      q = -32768;
      e.sat = 1'b1;
    end
    e.data = q[15:0];
    return e;
  endfunction

  entry_t mq[$];
  bit     m_s1v = 1'b0;
  entry_t m_s1e;
  bit     m_ovf = 1'b0;

  // Model: advance on each clock, clear on reset.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_s1v = 1'b0;
        m_ovf = 1'b0;
      end else begin
        bit pop;
        bit drop;
        pop  = (mq.size() > 0) && out_ready;
        drop = 1'b0;
        if (pop) void'(mq.pop_front());
        if (m_s1v) begin
          if (mq.size() < DEPTH) mq.push_back(m_s1e);
          else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clear_ovf) m_ovf = 1'b0;
        m_s1v = compare_res;
        if (compare_res) m_s1e = model_scale(res_in, int'(rshift), sat_en);
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("cyc_count", 64'(count), 64'(mq.size()));
      chk("cyc_ovf", 64'(overflow), 64'(m_ovf));
      if (mq.size() > 0) begin
        chk("cyc_data", 64'(out_data), 64'(mq[0].data));
        chk("cyc_sat", 64'(out_sat), 64'(mq[0].sat));
      end else begin
        chk("cyc_data_empty", 64'(out_data), 64'(0));
        chk("cyc_sat_empty", 64'(out_sat), 64'(0));
      end
    end
  end

  // One strobe; returns at the negedge after it was captured.
  task automatic strobe(input logic [31:0] r, input logic [4:0] sh, input logic s);
    compare_res = 1'b1;
    res_in = r;
    rshift = sh;
    sat_en = s;
    @(negedge clk);
    compare_res = 1'b0;
  endtask

  // Strobe and wait until the result reaches an empty FIFO head.
  task automatic run(input logic [31:0] r, input logic [4:0] sh, input logic s);
    strobe(r, sh, s);
    @(negedge clk);
  endtask

  // Check the head against literal values, then pop it.
  task automatic expect_head(input string name, input logic [15:0] d, input logic s);
    chk({name, "_valid"}, 64'(out_valid), 64'(1));
    chk({name, "_data"}, 64'(out_data), 64'(d));
    chk({name, "_sat"}, 64'(out_sat), 64'(s));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Truncation and two-cycle latency.
    strobe(32'h0000_1234, 5'd4, 1'b0);
    chk("lat_n1_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    expect_head("trunc", 16'h0123, 1'b0);

    // Rounding, both signs.
    run(32'h0000_0018, 5'd4, 1'b0);
    expect_head("round_pos", 16'h0002, 1'b0);
    run(32'hFFFF_FFE8, 5'd4, 1'b1);
    expect_head("round_neg", 16'hFFFF, 1'b0);

    // Saturation versus truncation.
    run(32'h0001_0000, 5'd0, 1'b1);
    expect_head("sat_hi", 16'h7FFF, 1'b1);
    run(32'hFFFF_0000, 5'd0, 1'b1);
    expect_head("sat_lo", 16'h8000, 1'b1);
    run(32'h0001_0000, 5'd0, 1'b0);
    expect_head("trunc_hi", 16'h0000, 1'b0);
    run(32'hFFFF_0000, 5'd0, 1'b0);
    expect_head("trunc_lo", 16'h0000, 1'b0);

    // Fill past capacity: six strobes, four kept, overflow set.
    for (int i = 1; i <= 6; i++) strobe(32'h10 + 32'(i), 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("full_count", 64'(count), 64'(4));
    chk("full_ovf", 64'(overflow), 64'(1));
    for (int i = 1; i <= 4; i++) expect_head("drain", 16'h10 + 16'(i), 1'b0);
    chk("drained_count", 64'(count), 64'(0));
    chk("ovf_sticky", 64'(overflow), 64'(1));
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'(0));

    // Push and pop together while full: nothing dropped.
    for (int i = 1; i <= 4; i++) strobe(32'h20 + 32'(i), 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("pp_full_count", 64'(count), 64'(4));
    strobe(32'h25, 5'd0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pp_count", 64'(count), 64'(4));
    chk("pp_ovf", 64'(overflow), 64'(0));
    for (int i = 2; i <= 5; i++) expect_head("pp_drain", 16'h20 + 16'(i), 1'b0);

    // Reset with entries queued and one in flight.
    for (int i = 1; i <= 3; i++) strobe(32'h30 + 32'(i), 5'd0, 1'b0);
    @(negedge clk);
    chk("pre_rst_count", 64'(count), 64'(3));
    strobe(32'h34, 5'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_count", 64'(count), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'(0));
    chk("post_rst_count", 64'(count), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
